rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Write-side front end for the 32x32 RISC-V register file.
- Buffers completed results (rd, data) from the execute/load paths in a small FIFO and drains them one per cycle into the register file's single write port (Add_Dest / Write_Data / Write_En).
- Provides two bypass lookup ports so decode sees results that are still queued and not yet committed.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CW, 3, width of Count; equals log2(DEPTH)+1.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- In_Valid  in  1  producer has a result this cycle.
- In_Ready  out  1  queue can accept; transfer when In_Valid && In_Ready.
- In_Dest  in  5  destination register rd.
- In_Data  in  32  result value.
- Drain_En  in  1  register file write port is available this cycle.
- Add_Dest  out  5  to register file, destination address.
- Write_Data  out  32  to register file, write value.
- Write_En  out  1  to register file, write strobe.
- Look_A  in  5  decode rs1 address.
- Look_B  in  5  decode rs2 address.
- Hit_A  out  1  Look_A matches a queued entry.
- Data_A  out  32  youngest queued value for Look_A; 0 on miss.
- Hit_B  out  1  same as Hit_A, for Look_B.
- Data_B  out  32  same as Data_A, for Look_B.
- Count  out  CW  number of queued entries.
- Empty  out  1  Count == 0.

Behaviour:
- State:
  - Circular buffer of DEPTH entries {rd[4:0], data[31:0]}.
  - Head pointer wr_ptr and tail pointer rd_ptr, log2(DEPTH) bits each, wrap modulo DEPTH.
  - Count register.
- Reset (RST=1 at posedge):
  - Pointers and Count go to 0; all queued entries are discarded, including during active draining.
  - With the queue empty, outputs are In_Ready=1, Empty=1, Count=0, Write_En=0, Add_Dest=0, Write_Data=0, Hit_A/B=0, Data_A/B=0.
  - RST has priority over push and pop in the same cycle.
- In_Ready:
  - Combinational, equal to (Count != DEPTH).
  - Does not look ahead on a same-cycle pop: when full, In_Ready=0 even if Drain_En=1.
- Push:
  - Occurs on In_Valid && In_Ready && (In_Dest != 0).
  - Writes entry[wr_ptr], then wr_ptr++.
- x0 filtering: In_Valid && In_Ready && In_Dest==0 completes the handshake but enqueues nothing; Count is unchanged.
- Drain (write port):
  - Write_En = Drain_En && !Empty, combinational.
  - Add_Dest/Write_Data = entry[rd_ptr] when !Empty; 0 when Empty.
  - Pop: on Write_En, rd_ptr++ at the same posedge at which the register file captures the write.
- Latency: an accepted entry is visible at the head, and can be written, no earlier than the cycle after acceptance; no input-to-write-port passthrough.
- Ordering: strict FIFO; a later write to the same rd always commits after the earlier one.
- Simultaneous push and pop: both happen; Count is unchanged; legal at any occupancy except full, where no push occurs.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Bypass lookup (per port, combinational):
  - Searches all valid entries, i.e. the Count entries starting at rd_ptr.
  - On multiple matches, the youngest entry (closest to wr_ptr) supplies Data.
  - Look address 0 always misses with Data=0.
  - The entry being drained this cycle still counts as a hit, since the register file updates only at the edge.
  - The same-cycle In_Data is not bypassed.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble; bypass age ordering stays correct across the wrap.

Test Plan:
- Reset then idle → Empty=1, Count=0, In_Ready=1, Write_En=0, Add_Dest=0, Write_Data=0.
- Push rd=5/0x11111111, then rd=5/0x22222222 with Drain_En=0; Look_A=5 → Hit_A=1, Data_A=0x22222222, Count=2. Then Drain_En=1 → writes to rd 5 in order 0x11111111 then 0x22222222 on consecutive cycles; Empty=1 afterwards.
- Fill DEPTH=4 with Drain_En=0 → Count=4, In_Ready=0. A 5th In_Valid is held and not accepted. Raise Drain_En → 5th accepted the cycle after the first pop; the 6 pushes wrap wr_ptr past 3 correctly.
- In_Valid with In_Dest=0, Data=0xDEADBEEF → handshake completes, Count stays 0, Write_En never asserts; Look_A=0 → Hit_A=0, Data_A=0.
- Count=2 with In_Valid=1 and Drain_En=1 held for 10 cycles → Count stays 2; the write stream exactly matches the input stream delayed by 2 entries.
- RST asserted with Count=3 and Drain_En=1 → after the edge Count=0, Write_En=0, Hit_A=Hit_B=0; none of the discarded entries is ever written.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// Write-side front end for the 32x32 register file: buffers completed results in a
// small FIFO, drains one per cycle into the single write port, and bypasses queued data to decode.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [4:0]    In_Dest,
  input  logic [31:0]   In_Data,
  input  logic          Drain_En,
  output logic [4:0]    Add_Dest,
  output logic [31:0]   Write_Data,
  output logic          Write_En,
  input  logic [4:0]    Look_A,
  input  logic [4:0]    Look_B,
  output logic          Hit_A,
  output logic [31:0]   Data_A,
  output logic          Hit_B,
  output logic [31:0]   Data_B,
  output logic [CW-1:0] Count,
  output logic          Empty
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  assign Count    = count_q;
  assign Empty    = (count_q == '0);
  assign In_Ready = (count_q != CW'(DEPTH));
  assign push     = In_Valid && In_Ready && (In_Dest != 5'd0) && !RST;

  // Reset discards the queue outright, so the head must not reach the register file that cycle either.
  assign Write_En   = Drain_En && !Empty && !RST;
  assign pop        = Write_En;
  assign Add_Dest   = Empty ? 5'd0  : dest_mem[rd_ptr];
  assign Write_Data = Empty ? 32'd0 : data_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      dest_mem[wr_ptr] <= In_Dest;
      data_mem[wr_ptr] <= In_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan oldest to youngest so the last match, the youngest, supplies the data.
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((CW'(i) < count_q) && (addr != 5'd0) && (dest_mem[idx] == addr))
        res = {1'b1, data_mem[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {Hit_A, Data_A} = lookup(Look_A);
    {Hit_B, Data_B} = lookup(Look_B);
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized and directed bench for rf_writeback_queue; a queue-based reference model
// predicts combinational outputs, and a scoreboard checks every register file write.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          In_Valid = 1'b0;
  logic          In_Ready;
  logic [4:0]    In_Dest = '0;
  logic [31:0]   In_Data = '0;
  logic          Drain_En = 1'b0;
  logic [4:0]    Add_Dest;
  logic [31:0]   Write_Data;
  logic          Write_En;
  logic [4:0]    Look_A = '0;
  logic [4:0]    Look_B = '0;
  logic          Hit_A, Hit_B;
  logic [31:0]   Data_A, Data_B;
  logic [CW-1:0] Count;
  logic          Empty;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t model_q[$];
  entry_t sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  rf_writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Dest(In_Dest), .In_Data(In_Data),
    .Drain_En(Drain_En), .Add_Dest(Add_Dest), .Write_Data(Write_Data), .Write_En(Write_En),
    .Look_A(Look_A), .Look_B(Look_B),
    .Hit_A(Hit_A), .Data_A(Data_A), .Hit_B(Hit_B), .Data_B(Data_B),
    .Count(Count), .Empty(Empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest queued entry for addr wins; address 0 never hits.
  function automatic logic [32:0] model_lookup(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].dest == addr) return {1'b1, model_q[i].data};
    return '0;
  endfunction

  task automatic checkOutput();
    logic [32:0] la, lb;
    int          sz;
    sz = model_q.size();
    la = model_lookup(Look_A);
    lb = model_lookup(Look_B);
    check("count",    32'(Count),    32'(sz));
    check("empty",    32'(Empty),    32'(sz == 0));
    check("in_ready", 32'(In_Ready), 32'(sz != DEPTH));
    check("write_en", 32'(Write_En), 32'(Drain_En && sz != 0));
    if (sz == 0) begin
      check("add_dest_empty",   32'(Add_Dest), 32'd0);
      check("write_data_empty", Write_Data,    32'd0);
    end
    check("hit_a",  32'(Hit_A), 32'(la[32]));
    check("data_a", Data_A,     la[31:0]);
    check("hit_b",  32'(Hit_B), 32'(lb[32]));
    check("data_b", Data_B,     lb[31:0]);
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic applyStimulus(input logic v, input logic [4:0] d, input logic [31:0] dat,
                               input logic dr, input logic [4:0] la, input logic [4:0] lb);
    bit do_push, do_pop;
    entry_t e;
    @(negedge CLK);
    In_Valid = v; In_Dest = d; In_Data = dat; Drain_En = dr; Look_A = la; Look_B = lb;
    #1;
    checkOutput();
    do_pop  = dr && (model_q.size() != 0);
    do_push = v && (model_q.size() != DEPTH) && (d != 5'd0);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      e.dest = d; e.data = dat;
      model_q.push_back(e);
      sb_q.push_back(e);
    end
  endtask

  task automatic resetDut(input logic [4:0] probe);
    @(negedge CLK);
    RST = 1'b1; In_Valid = 1'b0; Drain_En = 1'b1;
    @(negedge CLK);
    RST = 1'b0; Look_A = probe; Look_B = probe;
    model_q.delete();
    sb_q.delete();
    #1;
    checkOutput();
  endtask

  // Scoreboard monitor: every write must be the oldest outstanding accepted result.
  initial begin
    entry_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (!RST && Write_En) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL unexpected_write: got rd %0d data %h expected no write", Add_Dest, Write_Data);
        end else begin
          e = sb_q.pop_front();
          check("wr_dest", 32'(Add_Dest), 32'(e.dest));
          check("wr_data", Write_Data,     e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    resetDut(5'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Same rd twice: youngest bypassed, both written in order.
    applyStimulus(1, 5, 32'h11111111, 0, 5, 0);
    applyStimulus(1, 5, 32'h22222222, 0, 5, 5);
    applyStimulus(0, 0, 0, 0, 5, 5);
    applyStimulus(0, 0, 0, 1, 5, 0);
    applyStimulus(0, 0, 0, 1, 5, 0);
    applyStimulus(0, 0, 0, 0, 5, 0);

    // Fill, hold a fifth while full, then drain so pushes wrap.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 5'(i + 8), 32'(i * 32'h1010), 0, 9, 12);
    applyStimulus(1, 5'd20, 32'hA5A5A5A5, 0, 20, 9);
    applyStimulus(1, 5'd20, 32'hA5A5A5A5, 1, 20, 9);
    applyStimulus(1, 5'd20, 32'hA5A5A5A5, 1, 20, 10);
    applyStimulus(1, 5'd21, 32'h5A5A5A5A, 0, 21, 20);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 21, 20);

    // x0 result completes the handshake but never enqueues.
    applyStimulus(1, 0, 32'hDEADBEEF, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Steady stream at occupancy two.
    applyStimulus(1, 3, 32'h300, 0, 3, 4);
    applyStimulus(1, 4, 32'h400, 0, 3, 4);
    for (int i = 0; i < 10; i++) applyStimulus(1, 5'(3 + i % 2), 32'h1000 + 32'(i), 1, 3, 4);

    // Reset while draining with three queued.
    applyStimulus(1, 7, 32'h777, 0, 7, 3);
    resetDut(7);
    applyStimulus(0, 0, 0, 1, 7, 3);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) resetDut(5'($urandom_range(0, 7)));
      else applyStimulus(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    n = 0;
    while (model_q.size() != 0 && n < DEPTH + 2) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      n++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
